// File: rtl/irq_edge_arbiter_pkg.sv
// irq_edge_arbiter_pkg
// Shared constants, FSM state encoding and the priority encode helper used by
// the arbiter and by the downstream encoder stage.
//   N_IRQ       number of request lines (fixed at 4)
//   VEC_W       width of the encoded index
//   state_e     arbiter FSM states
//   prio_encode {valid, index} of the highest set bit (bit N_IRQ-1 highest)
//   idx_onehot  index to one-hot vector
package irq_edge_arbiter_pkg;

    localparam int N_IRQ = 4;
    localparam int VEC_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    function automatic logic [VEC_W:0] prio_encode(input logic [N_IRQ-1:0] req);
        logic [VEC_W:0] code;
        code = '0;
        for (int k = 0; k < N_IRQ; k++) begin
            if (req[k]) begin
                code = {1'b1, VEC_W'(k)};
            end
        end
        return code;
    endfunction

    function automatic logic [N_IRQ-1:0] idx_onehot(input logic [VEC_W-1:0] idx);
        return N_IRQ'(1) << idx;
    endfunction

endpackage

// File: rtl/irq_edge_arbiter_if.sv
// irq_edge_arbiter_if
// Request/handshake bundle between the interrupt sources, the arbiter and the
// downstream sequencer.
//   irq, mask, enable   request side inputs to the arbiter
//   ack, eoi            downstream handshake into the arbiter
//   intReq, out         presented request {valid, index}
//   inService           one-hot in-service interrupt
//   pending, noSig      status
// Modports: slave = arbiter side, master = sources/sequencer side.
interface irq_edge_arbiter_if;
    import irq_edge_arbiter_pkg::*;

    logic [N_IRQ-1:0] irq;
    logic [N_IRQ-1:0] mask;
    logic             enable;
    logic             ack;
    logic             eoi;
    logic             intReq;
    logic [VEC_W:0]   out;
    logic [N_IRQ-1:0] inService;
    logic [N_IRQ-1:0] pending;
    logic             noSig;

    modport slave (
        input  irq, mask, enable, ack, eoi,
        output intReq, out, inService, pending, noSig
    );

    modport master (
        output irq, mask, enable, ack, eoi,
        input  intReq, out, inService, pending, noSig
    );

endinterface

// File: rtl/irq_edge_arbiter_capture.sv
// irq_edge_capture
// Rising-edge detector and pending register for the request lines.
//   clk, reset  system clock, synchronous active-high reset
//   irq         raw request lines
//   clear       one-hot clear of the pending bit being acknowledged
//   pending     captured, not yet serviced requests
// Build option IRQ_SYNC_EN: route irq through a 2-flop synchronizer first.
module irq_edge_capture
    import irq_edge_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] clear,
    output logic [N_IRQ-1:0] pending
);

    logic [N_IRQ-1:0] irq_s;
    logic [N_IRQ-1:0] irq_prev_q;
    logic [N_IRQ-1:0] pending_q, pending_d;

`ifdef IRQ_SYNC_EN
    logic [N_IRQ-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq;
`endif

    // A new edge is OR-ed in after the clear so a collision keeps the bit set.
    always_comb begin
        pending_d = (pending_q & ~clear) | (irq_s & ~irq_prev_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
        end else begin
            irq_prev_q <= irq_s;
            pending_q  <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/irq_edge_arbiter.sv
// irq_edge_arbiter
// Captures request edges, arbitrates the highest unmasked pending request and
// presents it to the downstream sequencer via req/ack/eoi.
//   clk, reset  system clock, synchronous active-high reset
//   bus         irq_edge_arbiter_if.slave (requests, handshake, status)
// Build option IRQ_SYNC_EN (in irq_edge_capture) adds an input synchronizer.
//
// state      | meaning
// ST_IDLE    | waiting for enable and an eligible pending request
// ST_REQ     | request presented on out/intReq, frozen until ack or enable drop
// ST_SERVICE | request accepted, inService held until eoi
module irq_edge_arbiter
    import irq_edge_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    irq_edge_arbiter_if.slave  bus
);

    state_e           state_q, state_d;
    logic             int_req_q, int_req_d;
    logic [VEC_W:0]   out_q, out_d;
    logic [N_IRQ-1:0] in_service_q, in_service_d;
    logic [N_IRQ-1:0] clear;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] eligible;
    logic [VEC_W:0]   sel;

    irq_edge_capture u_capture (
        .clk     (clk),
        .reset   (reset),
        .irq     (bus.irq),
        .clear   (clear),
        .pending (pending)
    );

    assign eligible = pending & ~bus.mask;
    assign sel      = prio_encode(eligible);

    always_comb begin
        state_d      = state_q;
        int_req_d    = int_req_q;
        out_d        = out_q;
        in_service_d = in_service_q;
        clear        = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.enable && sel[VEC_W]) begin
                    state_d   = ST_REQ;
                    int_req_d = 1'b1;
                    out_d     = sel;
                end else begin
                    int_req_d = 1'b0;
                    out_d     = '0;
                end
            end
            ST_REQ: begin
                // ack takes precedence over an enable drop in the same cycle.
                if (bus.ack) begin
                    state_d      = ST_SERVICE;
                    int_req_d    = 1'b0;
                    out_d        = '0;
                    in_service_d = idx_onehot(out_q[VEC_W-1:0]);
                    clear        = idx_onehot(out_q[VEC_W-1:0]);
                end else if (!bus.enable) begin
                    state_d   = ST_IDLE;
                    int_req_d = 1'b0;
                    out_d     = '0;
                end
            end
            ST_SERVICE: begin
                if (bus.eoi) begin
                    state_d      = ST_IDLE;
                    in_service_d = '0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                int_req_d    = 1'b0;
                out_d        = '0;
                in_service_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            int_req_q    <= 1'b0;
            out_q        <= '0;
            in_service_q <= '0;
        end else begin
            state_q      <= state_d;
            int_req_q    <= int_req_d;
            out_q        <= out_d;
            in_service_q <= in_service_d;
        end
    end

    assign bus.intReq    = int_req_q;
    assign bus.out       = out_q;
    assign bus.inService = in_service_q;
    assign bus.pending   = pending;
    assign bus.noSig     = (eligible == '0);

endmodule

// File: tb/tb_irq_edge_arbiter.sv
module tb_irq_edge_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    irq_edge_arbiter_if bus ();

    irq_edge_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        bus.irq    = 4'h0;
        bus.mask   = 4'h0;
        bus.enable = 1'b1;
        bus.ack    = 1'b0;
        bus.eoi    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bus.irq    = 4'hF;
        bus.mask   = 4'h0;
        bus.enable = 1'b1;
        bus.ack    = 1'b0;
        bus.eoi    = 1'b0;
        tick();
        tick();
        checks++; if (bus.pending !== 4'h0) begin failures++; $display("FAIL reset_pending got=%b exp=%b", bus.pending, 4'h0); end
        checks++; if (bus.intReq !== 1'b0) begin failures++; $display("FAIL reset_intReq got=%b exp=0", bus.intReq); end
        checks++; if (bus.out !== 3'b000) begin failures++; $display("FAIL reset_out got=%b exp=000", bus.out); end
        checks++; if (bus.noSig !== 1'b1) begin failures++; $display("FAIL reset_noSig got=%b exp=1", bus.noSig); end
        checks++; if (bus.inService !== 4'h0) begin failures++; $display("FAIL reset_inService got=%b exp=0000", bus.inService); end
        reset = 1'b0;
        tick();
        checks++; if (bus.pending !== 4'hF) begin failures++; $display("FAIL reset_release_pending got=%b exp=1111", bus.pending); end
        checks++; if (bus.intReq !== 1'b0) begin failures++; $display("FAIL reset_release_intReq_early got=%b exp=0", bus.intReq); end
        tick();
        checks++; if (bus.out !== 3'b111) begin failures++; $display("FAIL reset_release_out got=%b exp=111", bus.out); end
        checks++; if (bus.intReq !== 1'b1) begin failures++; $display("FAIL reset_release_intReq got=%b exp=1", bus.intReq); end
    endtask

    task automatic test_single();
        do_reset();
        bus.irq = 4'b0010;
        tick();
        checks++; if (bus.pending !== 4'b0010) begin failures++; $display("FAIL single_capture got=%b exp=0010", bus.pending); end
        checks++; if (bus.intReq !== 1'b0) begin failures++; $display("FAIL single_intReq_e0 got=%b exp=0", bus.intReq); end
        bus.irq = 4'b0000;
        tick();
        checks++; if (bus.intReq !== 1'b1) begin failures++; $display("FAIL single_intReq got=%b exp=1", bus.intReq); end
        checks++; if (bus.out !== 3'b101) begin failures++; $display("FAIL single_out got=%b exp=101", bus.out); end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        checks++; if (bus.inService !== 4'b0010) begin failures++; $display("FAIL single_inService got=%b exp=0010", bus.inService); end
        checks++; if (bus.pending !== 4'b0000) begin failures++; $display("FAIL single_pending_clr got=%b exp=0000", bus.pending); end
        checks++; if ({bus.intReq, bus.out} !== 4'b0000) begin failures++; $display("FAIL single_ack_out got=%b exp=0000", {bus.intReq, bus.out}); end
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        checks++; if (bus.inService !== 4'b0000) begin failures++; $display("FAIL single_eoi got=%b exp=0000", bus.inService); end
        tick();
        checks++; if (bus.intReq !== 1'b0) begin failures++; $display("FAIL single_idle_intReq got=%b exp=0", bus.intReq); end
        checks++; if (bus.noSig !== 1'b1) begin failures++; $display("FAIL single_noSig got=%b exp=1", bus.noSig); end
    endtask

    task automatic test_priority_mask();
        do_reset();
        bus.irq = 4'b1001;
        tick();
        bus.irq = 4'b0000;
        tick();
        checks++; if (bus.out !== 3'b111) begin failures++; $display("FAIL prio_out got=%b exp=111", bus.out); end
        do_reset();
        bus.mask = 4'b1000;
        bus.irq  = 4'b1001;
        tick();
        bus.irq = 4'b0000;
        tick();
        checks++; if (bus.out !== 3'b100) begin failures++; $display("FAIL mask_out got=%b exp=100", bus.out); end
        checks++; if (bus.noSig !== 1'b0) begin failures++; $display("FAIL mask_noSig got=%b exp=0", bus.noSig); end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        checks++; if (bus.inService !== 4'b0001) begin failures++; $display("FAIL mask_inService got=%b exp=0001", bus.inService); end
        checks++; if (bus.pending !== 4'b1000) begin failures++; $display("FAIL mask_pending got=%b exp=1000", bus.pending); end
        checks++; if (bus.noSig !== 1'b1) begin failures++; $display("FAIL mask_noSig_masked got=%b exp=1", bus.noSig); end
        bus.eoi = 1'b1;
        tick();
        bus.eoi  = 1'b0;
        bus.mask = 4'b0000;
        tick();
        checks++; if (bus.out !== 3'b111) begin failures++; $display("FAIL unmask_out got=%b exp=111", bus.out); end
    endtask

    task automatic test_freeze();
        do_reset();
        bus.irq = 4'b0001;
        tick();
        bus.irq = 4'b0000;
        tick();
        checks++; if (bus.out !== 3'b100) begin failures++; $display("FAIL freeze_first got=%b exp=100", bus.out); end
        bus.irq = 4'b0100;
        tick();
        bus.irq = 4'b0000;
        checks++; if (bus.pending !== 4'b0101) begin failures++; $display("FAIL freeze_pending got=%b exp=0101", bus.pending); end
        tick();
        checks++; if (bus.out !== 3'b100) begin failures++; $display("FAIL freeze_hold got=%b exp=100", bus.out); end
        bus.mask = 4'b0001;
        tick();
        bus.mask = 4'b0000;
        checks++; if (bus.out !== 3'b100) begin failures++; $display("FAIL freeze_mask got=%b exp=100", bus.out); end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        checks++; if (bus.inService !== 4'b0001) begin failures++; $display("FAIL freeze_inService got=%b exp=0001", bus.inService); end
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        tick();
        checks++; if (bus.out !== 3'b110) begin failures++; $display("FAIL freeze_next got=%b exp=110", bus.out); end
    endtask

    task automatic test_enable_withdraw();
        do_reset();
        bus.irq = 4'b0100;
        tick();
        bus.irq = 4'b0000;
        tick();
        checks++; if (bus.out !== 3'b110) begin failures++; $display("FAIL withdraw_pre got=%b exp=110", bus.out); end
        bus.enable = 1'b0;
        tick();
        checks++; if ({bus.intReq, bus.out} !== 4'b0000) begin failures++; $display("FAIL withdraw_drop got=%b exp=0000", {bus.intReq, bus.out}); end
        checks++; if (bus.pending !== 4'b0100) begin failures++; $display("FAIL withdraw_pending got=%b exp=0100", bus.pending); end
        tick();
        checks++; if (bus.intReq !== 1'b0) begin failures++; $display("FAIL withdraw_idle got=%b exp=0", bus.intReq); end
        bus.enable = 1'b1;
        tick();
        checks++; if ({bus.intReq, bus.out} !== 4'b1110) begin failures++; $display("FAIL withdraw_repost got=%b exp=1110", {bus.intReq, bus.out}); end
        bus.enable = 1'b0;
        bus.ack    = 1'b1;
        tick();
        bus.ack    = 1'b0;
        bus.enable = 1'b1;
        checks++; if (bus.inService !== 4'b0100) begin failures++; $display("FAIL ack_beats_enable got=%b exp=0100", bus.inService); end
        checks++; if (bus.pending !== 4'b0000) begin failures++; $display("FAIL ack_beats_enable_pend got=%b exp=0000", bus.pending); end
    endtask

    task automatic test_ignored();
        do_reset();
        bus.enable = 1'b0;
        bus.irq    = 4'b0001;
        tick();
        bus.irq = 4'b0000;
        bus.ack = 1'b1;
        bus.eoi = 1'b1;
        tick();
        tick();
        bus.ack = 1'b0;
        bus.eoi = 1'b0;
        checks++; if (bus.pending !== 4'b0001) begin failures++; $display("FAIL ignore_pending got=%b exp=0001", bus.pending); end
        checks++; if ({bus.intReq, bus.inService} !== 5'b00000) begin failures++; $display("FAIL ignore_state got=%b exp=00000", {bus.intReq, bus.inService}); end
        bus.enable = 1'b1;
        tick();
        checks++; if (bus.out !== 3'b100) begin failures++; $display("FAIL ignore_then_req got=%b exp=100", bus.out); end
    endtask

    task automatic test_collision();
        do_reset();
        bus.irq = 4'b0010;
        tick();
        bus.irq = 4'b0000;
        tick();
        checks++; if (bus.out !== 3'b101) begin failures++; $display("FAIL coll_first got=%b exp=101", bus.out); end
        bus.ack = 1'b1;
        bus.irq = 4'b0010;
        tick();
        bus.ack = 1'b0;
        checks++; if (bus.pending !== 4'b0010) begin failures++; $display("FAIL coll_set_wins got=%b exp=0010", bus.pending); end
        checks++; if (bus.inService !== 4'b0010) begin failures++; $display("FAIL coll_inService got=%b exp=0010", bus.inService); end
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        tick();
        checks++; if (bus.out !== 3'b101) begin failures++; $display("FAIL coll_next got=%b exp=101", bus.out); end
        // Level still held high: acking must clear with no recapture.
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        checks++; if (bus.pending !== 4'b0000) begin failures++; $display("FAIL coll_level_once got=%b exp=0000", bus.pending); end
        bus.irq = 4'b0000;
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.irq = 4'b1100;
        tick();
        bus.irq = 4'b0000;
        tick();
        checks++; if (bus.out !== 3'b111) begin failures++; $display("FAIL b2b_first got=%b exp=111", bus.out); end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        checks++; if (bus.pending !== 4'b0100) begin failures++; $display("FAIL b2b_pending got=%b exp=0100", bus.pending); end
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        checks++; if ({bus.intReq, bus.inService} !== 5'b00000) begin failures++; $display("FAIL b2b_eoi got=%b exp=00000", {bus.intReq, bus.inService}); end
        tick();
        checks++; if ({bus.intReq, bus.out} !== 4'b1110) begin failures++; $display("FAIL b2b_next got=%b exp=1110", {bus.intReq, bus.out}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.irq = 4'b1001;
        tick();
        bus.irq = 4'b0000;
        tick();
        checks++; if (bus.intReq !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b exp=1", bus.intReq); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({bus.intReq, bus.out, bus.pending} !== 8'h00) begin failures++; $display("FAIL mid_clear got=%b exp=00000000", {bus.intReq, bus.out, bus.pending}); end
        tick();
        checks++; if (bus.intReq !== 1'b0) begin failures++; $display("FAIL mid_idle got=%b exp=0", bus.intReq); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_priority_mask();
        test_freeze();
        test_enable_withdraw();
        test_ignored();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
